// File: rtl/mul.sv
// Sequential unsigned shift-add multiplier.
// One partial-product bit per clock using a single combined product/multiplier
// register (acc) and one WIDTH+1 bit adder. Shares the start/ack handshake of the
// companion restoring divider so one controller can drive both units.
//
// Handshake (start/ack):
//   - start is sampled only in IDLE; an accepted start captures both operands on
//     that edge and moves to CALC. start seen in CALC or DONE is ignored (no queueing).
//   - ack is sampled only in DONE; it returns the unit to IDLE. If start and ack
//     are both high in DONE, ack wins and start is accepted one edge later.
//   - A start held high in IDLE is accepted every time IDLE is entered; the
//     requester drops start once it sees busy=1.
//   - product is registered and valid while done=1; it keeps its value through
//     IDLE until the next result overwrites it, and is cleared only by reset.
module mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ack,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    // Iteration counter only needs to reach WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [CW-1:0]        count_q,   count_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    // acc holds {partial product high half, remaining multiplier bits}; the top
    // bit is headroom so the adder's carry is never lost before the shift.
    logic [2*WIDTH:0]     acc_q,     acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Adder result for the current iteration, carry included.
    logic [WIDTH:0]       sum;

    // One conditional add of the multiplicand into the upper half of acc.
    always_comb begin
        sum = acc_q[2*WIDTH:WIDTH];
        if (acc_q[0]) begin
            sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        end
    end

    // Next-state and datapath update; every target gets a hold default first.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = multiplicand;
                    acc_d   = {{(WIDTH+1){1'b0}}, multiplier};
                    count_d = '0;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                // Add-then-shift: sum lands in the upper half, the consumed
                // multiplier bit falls off the bottom.
                acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
                if (count_q == LAST_COUNT) begin
                    // Count stays at WIDTH-1 so it never wraps.
                    product_d = acc_d[2*WIDTH-1:0];
                    state_d   = S_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    // Status outputs decode straight from the state register.
    assign busy      = (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for the shift-add multiplier: directed vector table,
// hand-written handshake/reset sequences, and random operands against a
// plain 64-bit multiply reference.
module tb_mul;

    localparam int W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              ack;
    logic [W-1:0]      multiplicand;
    logic [W-1:0]      multiplier;
    logic [2*W-1:0]    product;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    mul #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ack          (ack),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    // Reference: plain wide multiply.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request and wait for its accepting edge; leaves time at edge+1.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check({name, "_busy_on_accept"}, {63'd0, busy}, 64'd1);
    endtask

    // Wait for done from just after the accepting edge; optionally poke a
    // stray start (with operands 7,7) at a given CALC cycle.
    task automatic wait_done(input logic [2*W-1:0] exp, input string name, input int poke_at);
        int cycles;
        int busy_cnt;
        cycles   = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cnt++;
            if (cycles == poke_at) begin
                start        = 1'b1;
                multiplicand = 7;
                multiplier   = 7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(cycles), 64'(W));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({name, "_product"}, product, exp);
    endtask

    task automatic do_ack(input logic [2*W-1:0] exp, input string name);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check({name, "_done_after_ack"}, {63'd0, done}, 64'd0);
        check({name, "_busy_after_ack"}, {63'd0, busy}, 64'd0);
        check({name, "_product_kept"}, product, exp);
    endtask

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] rexp;
        int             hold_bad;
        int             cyc;

        vecs[0] = '{a: 32'd10,         b: 32'd3,          exp: 64'd30};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{a: 32'h1234_5678,  b: 32'd0,          exp: 64'd0};
        vecs[3] = '{a: 32'd1,          b: 32'h8000_0000,  exp: 64'h0000_0000_8000_0000};
        vecs[4] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  exp: 64'h4000_0000_0000_0000};
        vecs[5] = '{a: 32'd0,          b: 32'hFFFF_FFFF,  exp: 64'd0};

        // Reset block: two cycles low.
        rst = 1'b0;
        start = 1'b0;
        ack = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_product", product, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            wait_done(vecs[i].exp, $sformatf("vec%0d", i), -1);
            do_ack(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Stray start at CALC cycle 5 must not disturb 10*3.
        start_op(32'd10, 32'd3, "stray");
        wait_done(64'd30, "stray", 5);
        do_ack(64'd30, "stray");
        check("stray_not_queued_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-CALC.
        start_op(32'd9, 32'd9, "abort");
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_op(32'd5, 32'd5, "after_abort");
        wait_done(64'd25, "after_abort", -1);

        // start and ack together in DONE: ack wins, start accepted next edge.
        multiplicand = 32'd1000;
        multiplier   = 32'd2000;
        start = 1'b1;
        ack   = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("both_idle_busy", {63'd0, busy}, 64'd0);
        check("both_idle_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check("both_accepted_busy", {63'd0, busy}, 64'd1);
        wait_done(64'd2000000, "both", -1);
        do_ack(64'd2000000, "both");

        // ack in IDLE does nothing.
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("idle_ack_busy", {63'd0, busy}, 64'd0);
        check("idle_ack_done", {63'd0, done}, 64'd0);
        check("idle_ack_product", product, 64'd2000000);

        // ack withheld for 100 cycles: result held.
        start_op(32'hDEAD_BEEF, 32'h0000_0100, "hold");
        wait_done(64'h0000_00DE_ADBE_EF00, "hold", -1);
        hold_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!done || product !== 64'h0000_00DE_ADBE_EF00) hold_bad++;
        end
        check("hold_stable_bad_cycles", 64'(hold_bad), 64'd0);
        do_ack(64'h0000_00DE_ADBE_EF00, "hold");

        // Random operands against the reference.
        for (int n = 0; n < 500; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 10 == 0) ra = 32'hFFFF_FFFF;
            if (n % 13 == 0) rb = $urandom_range(0, 3);
            rexp = ref_mul(ra, rb);
            cyc = $urandom_range(0, 2);
            repeat (cyc) @(posedge clk);
            #1;
            start_op(ra, rb, "rand");
            wait_done(rexp, "rand", -1);
            cyc = $urandom_range(0, 3);
            repeat (cyc) @(posedge clk);
            #1;
            do_ack(rexp, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
